// File: rtl/gpioemu_bus_seq.sv
// Bus-master sequencer for the GPIO multiplier/popcount peripheral: turns operand
// pairs into a register-bus write/start/poll/read sequence and returns one result each.
module gpioemu_bus_seq #(
   parameter int          START_WAIT = 4,
   parameter int          POLL_LIMIT = 16,
   parameter logic [15:0] ADDR_A1    = 16'h037F,
   parameter logic [15:0] ADDR_A2    = 16'h0388,
   parameter logic [15:0] ADDR_CTRL  = 16'h03A0,
   parameter logic [15:0] ADDR_W     = 16'h0390,
   parameter logic [15:0] ADDR_L     = 16'h0398
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [23:0] cmd_a1,
   input  logic [23:0] cmd_a2,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_w,
   output logic [23:0] res_ones,
   output logic        res_ovf,
   output logic        res_timeout,
   output logic [15:0] saddress,
   output logic        swr,
   output logic        srd,
   output logic [31:0] sdata_wr,
   input  logic [31:0] sdata_rd,
   output logic        busy,
   output logic [15:0] op_count
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never depends on ready, and payloads stay stable while valid waits for ready.
   typedef enum logic [3:0] {
      S_IDLE, S_WR_A1, S_WR_A2, S_WR_CTRL, S_WAIT, S_POLL, S_RD_W, S_RD_L, S_OUT
   } state_t;
   typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

   localparam logic [15:0] WAIT_LAST = 16'(START_WAIT - 1);
   localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);

   state_t      state, state_d;
   phase_t      phase, phase_d;
   logic [15:0] wait_cnt, wait_cnt_d, poll_cnt, poll_cnt_d;
   logic [23:0] a2_q, a2_d;
   logic [15:0] saddress_d, op_count_d;
   logic        swr_d, srd_d, res_valid_d, res_ovf_d, res_timeout_d;
   logic [31:0] sdata_wr_d, res_w_d;
   logic [23:0] res_ones_d;
   logic        is_wr;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign is_wr     = (state == S_WR_A1) || (state == S_WR_A2) || (state == S_WR_CTRL);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         phase       <= PH_SETUP;
         wait_cnt    <= '0;
         poll_cnt    <= '0;
         a2_q        <= '0;
         saddress    <= '0;
         swr         <= 1'b0;
         srd         <= 1'b0;
         sdata_wr    <= '0;
         res_valid   <= 1'b0;
         res_w       <= '0;
         res_ones    <= '0;
         res_ovf     <= 1'b0;
         res_timeout <= 1'b0;
         op_count    <= '0;
      end else begin
         state       <= state_d;
         phase       <= phase_d;
         wait_cnt    <= wait_cnt_d;
         poll_cnt    <= poll_cnt_d;
         a2_q        <= a2_d;
         saddress    <= saddress_d;
         swr         <= swr_d;
         srd         <= srd_d;
         sdata_wr    <= sdata_wr_d;
         res_valid   <= res_valid_d;
         res_w       <= res_w_d;
         res_ones    <= res_ones_d;
         res_ovf     <= res_ovf_d;
         res_timeout <= res_timeout_d;
         op_count    <= op_count_d;
      end
   end

   always_comb begin
      state_d       = state;
      phase_d       = phase;
      wait_cnt_d    = wait_cnt;
      poll_cnt_d    = poll_cnt;
      a2_d          = a2_q;
      saddress_d    = saddress;
      swr_d         = 1'b0;
      srd_d         = 1'b0;
      sdata_wr_d    = sdata_wr;
      res_valid_d   = res_valid;
      res_w_d       = res_w;
      res_ones_d    = res_ones;
      res_ovf_d     = res_ovf;
      res_timeout_d = res_timeout;
      op_count_d    = op_count;

      unique case (state)
         S_IDLE: begin
            // a1 rides straight into sdata_wr; only a2 needs its own holding register
            if (cmd_valid) begin
               a2_d          = cmd_a2;
               res_ovf_d     = 1'b0;
               res_timeout_d = 1'b0;
               poll_cnt_d    = '0;
               state_d       = S_WR_A1;
               phase_d       = PH_SETUP;
               saddress_d    = ADDR_A1;
               sdata_wr_d    = {8'h0, cmd_a1};
            end
         end
         S_WR_A1, S_WR_A2, S_WR_CTRL, S_POLL, S_RD_W, S_RD_L: begin
            unique case (phase)
               PH_SETUP: begin
                  phase_d = PH_STROBE;
                  swr_d   = is_wr;
                  srd_d   = ~is_wr;
               end
               PH_STROBE: phase_d = PH_HOLD;
               default: begin
                  // end of HOLD: read data is valid now, and the next access sets up
                  phase_d = PH_SETUP;
                  case (state)
                     S_WR_A1: begin
                        state_d    = S_WR_A2;
                        saddress_d = ADDR_A2;
                        sdata_wr_d = {8'h0, a2_q};
                     end
                     S_WR_A2: begin
                        state_d    = S_WR_CTRL;
                        saddress_d = ADDR_CTRL;
                        sdata_wr_d = '0;
                     end
                     S_WR_CTRL: begin
                        wait_cnt_d = '0;
                        state_d    = (START_WAIT == 0) ? S_POLL : S_WAIT;
                     end
                     S_POLL: begin
                        if (sdata_rd[1]) begin
                           res_ovf_d  = ~sdata_rd[0];
                           state_d    = S_RD_W;
                           saddress_d = ADDR_W;
                        end else if (poll_cnt == POLL_LAST) begin
                           res_timeout_d = 1'b1;
                           res_ovf_d     = 1'b0;
                           res_w_d       = '0;
                           res_ones_d    = '0;
                           res_valid_d   = 1'b1;
                           state_d       = S_OUT;
                        end else begin
                           poll_cnt_d = poll_cnt + 16'd1;
                        end
                     end
                     S_RD_W: begin
                        res_w_d    = sdata_rd;
                        state_d    = S_RD_L;
                        saddress_d = ADDR_L;
                     end
                     S_RD_L: begin
                        res_ones_d  = sdata_rd[23:0];
                        res_valid_d = 1'b1;
                        state_d     = S_OUT;
                     end
                     default: state_d = S_IDLE;
                  endcase
               end
            endcase
         end
         S_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               state_d    = S_POLL;
               phase_d    = PH_SETUP;
               saddress_d = ADDR_CTRL;
            end else begin
               wait_cnt_d = wait_cnt + 16'd1;
            end
         end
         S_OUT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               op_count_d  = op_count + 16'd1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
